lsu_bus_if: RTL and testbench
=============================

# lsu_bus_if

Load/store unit that carries out the memory commands the instruction decoder emits (`mem_rd`, `mem_wr`, `mem_ctrl`) against a word-wide data bus with a request/grant/response handshake.

- Stores: forms byte enables and lane-replicated write data.
- Loads: extracts, sign-extends or zero-extends read data.
- Stalls the core while a bus transaction is outstanding.
- Flags misaligned or inconsistent accesses without touching the bus.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (fixed 32; byte-lane logic assumes 4 lanes)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `mem_rd`  in  1  load request from decoder
- `mem_wr`  in  1  store request from decoder
- `mem_ctrl`  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW
- `addr`  in  AW  effective address (ALU result)
- `wdata`  in  32  store source (rs2)
- `rdata`  out  32  formatted load result, registered
- `stall`  out  1  core must hold PC/inputs while high
- `access_err`  out  1  one-cycle pulse: misaligned or encoding mismatch
- `bus_req`  out  1  bus request, held until grant
- `bus_we`  out  1  1 = write
- `bus_addr`  out  AW  word address (`addr` with bits [1:0] = 0)
- `bus_be`  out  4  byte enables
- `bus_wdata`  out  32  lane-placed write data
- `bus_gnt`  in  1  request accepted this cycle
- `bus_rvalid`  in  1  read data valid
- `bus_rdata`  in  32  read data word

## Operation
- Request condition: `mem_rd | mem_wr`. Direction comes from `mem_wr`; if both are high, the access is a store.
- Validity check; `access_err` is raised when any of the following holds:
  - the store encoding does not match the direction (`mem_wr` with `mem_ctrl` < 101, or `mem_rd` only with `mem_ctrl` ≥ 101)
  - a halfword access has `addr[0]` = 1
  - a word access has `addr[1:0]` ≠ 00
- Store formatting:
  - SB: `bus_wdata` = {4{wdata[7:0]}}, `bus_be` = 0001 << addr[1:0]
  - SH: `bus_wdata` = {2{wdata[15:0]}}, `bus_be` = 0011 << {addr[1],0}
  - SW: `bus_wdata` = wdata, `bus_be` = 1111
- Load requests drive `bus_be` = 1111.
- Load extraction: shift `bus_rdata` right by 8*addr[1:0], then:
  - LB / LH: sign-extend bit 7 / bit 15
  - LBU / LHU: zero-extend
  - LW: pass through
- Registered load state: `addr[1:0]` and the load type are latched at request time; extraction uses the latched copies.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE, valid request: latch `bus_addr`/`be`/`wdata`/`we`/type, go to REQ, `stall` = 1 (combinational).
  - IDLE, invalid request: `access_err` = 1 for that cycle, stay in IDLE, `stall` = 0, no bus activity, `rdata` unchanged.
  - IDLE, no request: `stall` = 0.
  - REQ: `bus_req` = 1, `stall` = 1. On `bus_gnt`, a store goes to DONE and a load goes to WAIT. Bus outputs stay stable until grant.
  - WAIT: `stall` = 1. On `bus_rvalid`, register the formatted data into `rdata` and go to DONE.
  - DONE: `stall` = 0 and the core advances. Always returns to IDLE; DONE never re-launches an access.
- `bus_rvalid` outside WAIT is ignored.
- `rdata` holds its value until the next load completes; stores do not alter it.

## Timing
- Reset values:
  - state = IDLE
  - `bus_req`, `bus_we`, `access_err`, `stall` = 0
  - `bus_addr`, `bus_be`, `bus_wdata`, `rdata` = 0
- `stall` is forced to 0 while `rst` is high.
- Store, zero-wait grant: IDLE(stall) → REQ(gnt) → DONE. Two stall cycles; the instruction retires in the 3rd cycle.
- Load, zero-wait grant, `bus_rvalid` the cycle after grant: IDLE → REQ → WAIT → DONE. Three stall cycles; `rdata` is valid in DONE.
- `bus_rvalid` is accepted no earlier than the cycle after `bus_gnt`.
- Each wait cycle of `bus_gnt` or `bus_rvalid` adds exactly one stall cycle. There is no timeout.
- Reset in REQ or WAIT: next state is IDLE and `bus_req` drops on that edge. A late `bus_rvalid` is discarded and `rdata` stays 0.
- Core contract: inputs are stable while `stall` = 1. Behaviour under input changes during stall is undefined (not checked).
- Throughput: one access per 3 cycles minimum.

## Test plan
- SB, `addr` = 0x1003, `wdata` = 0x000000AB, `bus_gnt` immediate → `bus_addr` = 0x1000, `bus_be` = 1000, `bus_wdata` = 0xABABABAB, `bus_we` = 1, stall high for exactly 2 cycles.
- LB then LBU, `addr` = 0x2002, `bus_rdata` = 0x0080FF00, `bus_gnt` delayed 2 cycles → `rdata` = 0xFFFFFF80, then 0x00000080; stall lengths 5 and 5.
- LH at 0x3002, `bus_rdata` = 0x8001_1234 → `rdata` = 0xFFFF8001. LHU at 0x3000 → 0x00001234. LW → 0x80011234.
- Misaligned LW at 0x4001, SH at 0x4003, and `mem_wr` with `mem_ctrl` = 010 → `access_err` pulses 1 cycle each, `bus_req` never asserts, stall = 0, `rdata` unchanged.
- Reset asserted in WAIT, then `bus_rvalid` with 0xDEADBEEF the next cycle → `bus_req` = 0, state IDLE, `rdata` = 0, stall = 0.
- Back-to-back SW then LW with no idle gap → SW retires in cycle 3; the LW request is sampled in IDLE in cycle 4 and launched exactly once.

Source files
------------

// File: rtl/lsu_bus_if.sv
// Load/store unit bridging decoder memory commands onto a req/gnt/rvalid word bus.
// Handles byte-lane placement for stores, extraction/extension for loads, and core stall.
module lsu_bus_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic [2:0]    mem_ctrl,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          stall,
  output logic          access_err,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_gnt,
  input  logic          bus_rvalid,
  input  logic [DW-1:0] bus_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [2:0] C_LB  = 3'd0;
  localparam logic [2:0] C_LH  = 3'd1;
  localparam logic [2:0] C_LW  = 3'd2;
  localparam logic [2:0] C_LBU = 3'd3;
  localparam logic [2:0] C_LHU = 3'd4;
  localparam logic [2:0] C_SB  = 3'd5;
  localparam logic [2:0] C_SH  = 3'd6;
  localparam logic [2:0] C_SW  = 3'd7;

  state_t          state_q, state_d;
  logic            bus_req_q, bus_req_d;
  logic            bus_we_q, bus_we_d;
  logic [AW-1:0]   bus_addr_q, bus_addr_d;
  logic [3:0]      bus_be_q, bus_be_d;
  logic [DW-1:0]   bus_wdata_q, bus_wdata_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [1:0]      off_q, off_d;
  logic [2:0]      ltype_q, ltype_d;

  logic            req, ctrl_store, is_half, is_word, bad;
  logic [3:0]      st_be;
  logic [DW-1:0]   st_wdata, ld_shift, ld_fmt;

  // Request decode and validity check
  always_comb begin
    req        = mem_rd | mem_wr;
    ctrl_store = (mem_ctrl >= C_SB);
    is_half    = (mem_ctrl == C_LH) || (mem_ctrl == C_LHU) || (mem_ctrl == C_SH);
    is_word    = (mem_ctrl == C_LW) || (mem_ctrl == C_SW);
    bad        = (mem_wr & ~ctrl_store) | (~mem_wr & mem_rd & ctrl_store) |
                 (is_half & addr[0]) | (is_word & (addr[1:0] != 2'b00));
  end

  // Store lane placement; loads always enable the full word
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = wdata;
    if (mem_wr) begin
      case (mem_ctrl)
        C_SB: begin
          st_be    = 4'(4'b0001 << addr[1:0]);
          st_wdata = {4{wdata[7:0]}};
        end
        C_SH: begin
          st_be    = 4'(4'b0011 << {addr[1], 1'b0});
          st_wdata = {2{wdata[15:0]}};
        end
        default: begin
          st_be    = 4'b1111;
          st_wdata = wdata;
        end
      endcase
    end
  end

  // Load extraction from the offset/type captured at request time
  always_comb begin
    ld_shift = bus_rdata >> {off_q, 3'b000};
    case (ltype_q)
      C_LB:    ld_fmt = {{(DW-8){ld_shift[7]}}, ld_shift[7:0]};
      C_LH:    ld_fmt = {{(DW-16){ld_shift[15]}}, ld_shift[15:0]};
      C_LBU:   ld_fmt = {{(DW-8){1'b0}}, ld_shift[7:0]};
      C_LHU:   ld_fmt = {{(DW-16){1'b0}}, ld_shift[15:0]};
      default: ld_fmt = ld_shift;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    off_d       = off_q;
    ltype_d     = ltype_q;
    stall       = 1'b0;
    access_err  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (bad) begin
            access_err = 1'b1;
          end else begin
            state_d     = S_REQ;
            stall       = 1'b1;
            bus_req_d   = 1'b1;
            bus_we_d    = mem_wr;
            bus_addr_d  = {addr[AW-1:2], 2'b00};
            bus_be_d    = st_be;
            bus_wdata_d = st_wdata;
            off_d       = addr[1:0];
            ltype_d     = mem_ctrl;
          end
        end
      end
      S_REQ: begin
        stall = 1'b1;
        if (bus_gnt) begin
          bus_req_d = 1'b0;
          state_d   = bus_we_q ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (bus_rvalid) begin
          rdata_d = ld_fmt;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) begin
      stall      = 1'b0;
      access_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      rdata_q     <= '0;
      off_q       <= '0;
      ltype_q     <= '0;
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      off_q       <= off_d;
      ltype_q     <= ltype_d;
    end
  end

  assign rdata     = rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Directed + randomized bench for lsu_bus_if against a byte-level reference model.
module tb_lsu_bus_if;

  logic        clk, rst, mem_rd, mem_wr;
  logic [2:0]  mem_ctrl;
  logic [31:0] addr, wdata, rdata;
  logic        stall, access_err, bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] model_rdata = 32'h0;

  lsu_bus_if #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_ctrl(mem_ctrl),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .access_err(access_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes for each command encoding
  function automatic int size_of(input logic [2:0] c);
    case (c)
      3'd0, 3'd3, 3'd5: return 1;
      3'd1, 3'd4, 3'd6: return 2;
      default:          return 4;
    endcase
  endfunction

  function automatic logic exp_err(input logic rd, input logic wr, input logic [2:0] c,
                                   input logic [31:0] a);
    int sz = size_of(c);
    logic is_st = (c >= 3'd5);
    logic dir_bad = wr ? !is_st : (rd && is_st);
    return dir_bad || ((int'(a[1:0]) % sz) != 0);
  endfunction

  function automatic logic [3:0] exp_be(input logic wr, input logic [2:0] c, input logic [31:0] a);
    int sz = size_of(c);
    if (!wr) return 4'b1111;
    return 4'(((1 << sz) - 1) << int'(a[1:0]));
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] c, input logic [31:0] w);
    int sz = size_of(c);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = w[8*(j % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] c, input logic [31:0] a,
                                           input logic [31:0] d);
    int sz = size_of(c);
    longint v = (longint'(d) >> (8 * int'(a[1:0]))) & ((64'd1 << (8 * sz)) - 1);
    if ((c == 3'd0 || c == 3'd1) && v >= (64'd1 << (8 * sz - 1))) v = v - (64'd1 << (8 * sz));
    return 32'(v);
  endfunction

  // One decoder command; entered and left on a falling edge
  task automatic access(input logic rd, input logic wr, input logic [2:0] c,
                        input logic [31:0] a, input logic [31:0] w,
                        input int gd, input int rvd, input logic [31:0] rword);
    logic e = exp_err(rd, wr, c, a);
    int exp_stall = e ? 0 : (wr ? 2 + gd : 3 + gd + rvd);
    int scnt = 0, rq = 0, wc = 0;
    logic fin = 0, granted = 0;
    mem_rd = rd; mem_wr = wr; mem_ctrl = c; addr = a; wdata = w;
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      #1;
      if (cyc == 0) begin
        check("access_err", 32'(access_err), 32'(e));
        check("bus_req_idle", 32'(bus_req), 32'h0);
      end
      if (stall) scnt++;
      if (!stall) begin
        if (cyc > 0) check("bus_req_done", 32'(bus_req), 32'h0);
        fin = 1;
      end else if (bus_req) begin
        if (rq == gd) begin
          bus_gnt = 1'b1;
          granted = 1;
          check("bus_we", 32'(bus_we), 32'(wr));
          check("bus_addr", bus_addr, {a[31:2], 2'b00});
          check("bus_be", 32'(bus_be), 32'(exp_be(wr, c, a)));
          if (wr) check("bus_wdata", bus_wdata, exp_wd(c, w));
        end
        rq++;
      end else if (granted && !wr) begin
        if (wc == rvd) begin
          bus_rvalid = 1'b1;
          bus_rdata  = rword;
        end
        wc++;
      end
      @(negedge clk);
      bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
    end
    check("finished", 32'(fin), 32'h1);
    check("stall_cycles", 32'(scnt), 32'(exp_stall));
    if (!e && !wr) model_rdata = exp_load(c, a, rword);
    #1 check("rdata", rdata, model_rdata);
    mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  // Quiet cycle, optionally with a stray rvalid that must be ignored
  task automatic idle(input logic stray);
    mem_rd = 1'b0; mem_wr = 1'b0;
    bus_rvalid = stray; bus_rdata = $urandom;
    #1;
    check("idle_bus_req", 32'(bus_req), 32'h0);
    check("idle_stall", 32'(stall), 32'h0);
    check("idle_err", 32'(access_err), 32'h0);
    @(negedge clk);
    bus_rvalid = 1'b0;
    #1 check("idle_rdata", rdata, model_rdata);
  endtask

  initial begin
    rst = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; mem_ctrl = 3'd2; addr = 32'h100;
    wdata = 0; bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'h0);
    check("rst_err", 32'(access_err), 32'h0);
    check("rst_req", 32'(bus_req), 32'h0);
    check("rst_we", 32'(bus_we), 32'h0);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_be", 32'(bus_be), 32'h0);
    check("rst_wdata", bus_wdata, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0; mem_rd = 1'b0;
    idle(1'b0);

    access(0, 1, 3'd5, 32'h1003, 32'h000000AB, 0, 0, 32'h0);
    check("sb_be", 32'(bus_be), 32'h8);
    check("sb_wdata", bus_wdata, 32'hABABABAB);
    idle(1'b0);
    access(1, 0, 3'd0, 32'h2002, 0, 2, 0, 32'h0080FF00);
    check("lb_val", rdata, 32'hFFFFFF80);
    access(1, 0, 3'd3, 32'h2002, 0, 2, 0, 32'h0080FF00);
    check("lbu_val", rdata, 32'h00000080);
    access(1, 0, 3'd1, 32'h3002, 0, 0, 1, 32'h80011234);
    check("lh_val", rdata, 32'hFFFF8001);
    access(1, 0, 3'd4, 32'h3000, 0, 1, 0, 32'h80011234);
    check("lhu_val", rdata, 32'h00001234);
    access(1, 0, 3'd2, 32'h3000, 0, 0, 2, 32'h80011234);
    check("lw_val", rdata, 32'h80011234);
    idle(1'b1);
    access(1, 0, 3'd2, 32'h4001, 0, 0, 0, 32'h0);
    idle(1'b0);
    access(0, 1, 3'd6, 32'h4003, 32'h5555, 0, 0, 32'h0);
    idle(1'b0);
    access(0, 1, 3'd2, 32'h4000, 32'h5555, 0, 0, 32'h0);
    idle(1'b0);
    access(1, 0, 3'd7, 32'h4000, 0, 0, 0, 32'h0);
    idle(1'b0);
    check("err_rdata_kept", rdata, 32'h80011234);

    // back-to-back store then load with no idle gap
    access(0, 1, 3'd7, 32'h6000, 32'hCAFEF00D, 0, 0, 32'h0);
    access(1, 0, 3'd2, 32'h6004, 0, 0, 0, 32'h13572468);
    idle(1'b0);

    // reset while waiting on read data
    mem_rd = 1'b1; mem_ctrl = 3'd2; addr = 32'h5000;
    #1 check("rw_stall_idle", 32'(stall), 32'h1);
    @(negedge clk);
    #1 check("rw_req", 32'(bus_req), 32'h1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    #1 check("rw_stall_wait", 32'(stall), 32'h1);
    rst = 1'b1;
    #1 check("rw_stall_rst", 32'(stall), 32'h0);
    @(negedge clk);
    rst = 1'b0; mem_rd = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hDEADBEEF;
    #1;
    check("rw_req_drop", 32'(bus_req), 32'h0);
    check("rw_stall_after", 32'(stall), 32'h0);
    @(negedge clk);
    bus_rvalid = 1'b0;
    model_rdata = 32'h0;
    #1 check("rw_rdata", rdata, 32'h0);
    idle(1'b0);

    for (int n = 0; n < 80; n++) begin
      logic rd, wr;
      logic [2:0] c;
      int pick = $urandom_range(0, 9);
      rd = (pick < 5) || (pick == 9);
      wr = (pick >= 5);
      c  = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) c = wr ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      access(rd, wr, c, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 1) == 1) idle(1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
